// File: rtl/counter_sequencer_pkg.sv
// Shared definitions for the counter sequencer: FSM state encoding.
package counter_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/counter_sequencer_cnt_core.sv
// Count register with synchronous clear (priority) and increment enable.
module seq_cnt_core #(
    parameter int DWIDTH = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              en_i,
    output logic [DWIDTH-1:0] cnt_o
);

    logic [DWIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)     cnt_d = '0;
        else if (en_i) cnt_d = cnt_q + DWIDTH'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/counter_sequencer.sv
// Run-control sequencer around an enable counter: start/stop/pause, one-shot or
// periodic counting 0..N-1, done strobe and completed-period tally.
module counter_sequencer
    import counter_sequencer_pkg::*;
#(
    parameter int DWIDTH = 7,
    parameter int PWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic              pause_i,
    input  logic              periodic_i,
    input  logic [DWIDTH-1:0] limit_i,
    output logic [DWIDTH-1:0] cnt_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [PWIDTH-1:0] period_o
);

    state_e            state_q, state_d;
    logic [DWIDTH-1:0] limit_q, limit_d;
    logic              periodic_q, periodic_d;
    logic [PWIDTH-1:0] period_q, period_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [DWIDTH-1:0] cnt;
    logic              running, idle_like, start_ok, cnt_en_raw, terminal;
    logic              cnt_clr, cnt_en;

    assign running   = (state_q == ST_RUN) || (state_q == ST_PAUSE);
    assign idle_like = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign start_ok  = start_i && idle_like && (limit_i != '0);
    // Leaving PAUSE with pause_i low counts in that same cycle, so no count is lost.
    assign cnt_en_raw = running && !pause_i && !stop_i;
    assign terminal   = cnt_en_raw && (cnt == limit_q - DWIDTH'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (stop_i)                  state_d = ST_IDLE;
        else if (start_ok)           state_d = ST_RUN;
        else if (terminal)           state_d = periodic_q ? ST_RUN : ST_DONE;
        else if (running && pause_i) state_d = ST_PAUSE;
        else if (running)            state_d = ST_RUN;
    end

    always_comb begin
        limit_d    = limit_q;
        periodic_d = periodic_q;
        period_d   = period_q;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        if (stop_i) begin
            cnt_clr = 1'b1;
        end else if (start_ok) begin
            limit_d    = limit_i;
            periodic_d = periodic_i;
            period_d   = '0;
            cnt_clr    = 1'b1;
        end else if (start_i && idle_like) begin
            err_d = 1'b1;
        end else if (terminal) begin
            done_d   = 1'b1;
            period_d = period_q + PWIDTH'(1);
            cnt_clr  = periodic_q;
        end else begin
            cnt_en = cnt_en_raw;
        end
        busy_d = (state_d == ST_RUN) || (state_d == ST_PAUSE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            limit_q    <= '0;
            periodic_q <= 1'b0;
            period_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            limit_q    <= limit_d;
            periodic_q <= periodic_d;
            period_q   <= period_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    seq_cnt_core #(.DWIDTH(DWIDTH)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .cnt_o (cnt)
    );

    assign cnt_o    = cnt;
    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign err_o    = err_q;
    assign period_o = period_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Self-checking bench: directed scenarios plus random commands against a cycle model.
module tb_counter_sequencer;

    localparam int DW = 7;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_i = 1'b0, stop_i = 1'b0, pause_i = 1'b0, periodic_i = 1'b0;
    logic [DW-1:0] limit_i = '0;
    logic [DW-1:0] cnt_o;
    logic          busy_o, done_o, err_o;
    logic [PW-1:0] period_o;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state
    bit m_run, m_per, m_done, m_err;
    int m_cnt, m_lim, m_period;

    counter_sequencer #(.DWIDTH(DW), .PWIDTH(PW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .stop_i     (stop_i),
        .pause_i    (pause_i),
        .periodic_i (periodic_i),
        .limit_i    (limit_i),
        .cnt_o      (cnt_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .period_o   (period_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_per = 0; m_done = 0; m_err = 0;
        m_cnt = 0; m_lim = 0; m_period = 0;
    endtask

    task automatic model_step(input bit st, input bit sp, input bit pa, input bit pe, input int lim);
        m_done = 0;
        m_err  = 0;
        if (sp) begin
            m_run = 0;
            m_cnt = 0;
        end else if (st && !m_run) begin
            if (lim == 0) m_err = 1;
            else begin
                m_run = 1; m_cnt = 0; m_period = 0; m_lim = lim; m_per = pe;
            end
        end else if (m_run && !pa) begin
            if (m_cnt == m_lim - 1) begin
                m_done   = 1;
                m_period = (m_period + 1) % (1 << PW);
                if (m_per) m_cnt = 0;
                else       m_run = 0;
            end else begin
                m_cnt++;
            end
        end
    endtask

    task automatic check_outs(input string tag);
        chk({tag, ".cnt"},    32'(cnt_o),    32'(m_cnt));
        chk({tag, ".busy"},   32'(busy_o),   32'(m_run));
        chk({tag, ".done"},   32'(done_o),   32'(m_done));
        chk({tag, ".err"},    32'(err_o),    32'(m_err));
        chk({tag, ".period"}, 32'(period_o), 32'(m_period));
    endtask

    task automatic step(input string tag, input bit st, input bit sp, input bit pa,
                        input bit pe, input int lim);
        @(negedge clk);
        start_i = st; stop_i = sp; pause_i = pa; periodic_i = pe; limit_i = DW'(lim);
        @(posedge clk);
        model_step(st, sp, pa, pe, lim);
        #1;
        check_outs(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int waited;
        bool_done_seen: begin end
        model_reset();
        #12;
        check_outs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // One-shot to 100
        step("t1.start", 1, 0, 0, 0, 100);
        idle("t1.run", 100);
        chk("t1.final_cnt", 32'(cnt_o), 32'd99);
        chk("t1.final_period", 32'(period_o), 32'd1);
        idle("t1.hold", 3);

        // Periodic, limit 5, 12 cycles
        step("t2.start", 1, 0, 0, 1, 5);
        idle("t2.run", 12);
        chk("t2.period", 32'(period_o), 32'd2);
        step("t2.stop", 0, 1, 0, 0, 0);

        // Pause 3 cycles at cnt=4, done arrives 3 cycles late
        step("t3.start", 1, 0, 0, 0, 10);
        idle("t3.run", 4);
        chk("t3.at4", 32'(cnt_o), 32'd4);
        for (int i = 0; i < 3; i++) begin
            step("t3.pause", 0, 0, 1, 0, 0);
            chk("t3.hold", 32'(cnt_o), 32'd4);
        end
        waited = 3;
        while (done_o !== 1'b1 && waited < 40) begin
            step("t3.resume", 0, 0, 0, 0, 0);
            waited++;
        end
        chk("t3.done_latency", 32'(waited), 32'd9);

        // Stop coincides with terminal
        step("t4.start", 1, 0, 0, 0, 3);
        idle("t4.run", 2);
        step("t4.stop", 0, 1, 0, 0, 0);
        chk("t4.cnt", 32'(cnt_o), 32'd0);
        chk("t4.done", 32'(done_o), 32'd0);
        chk("t4.period", 32'(period_o), 32'd0);

        // Rejected start, then start ignored while running
        step("t5.err", 1, 0, 0, 0, 0);
        chk("t5.err_strobe", 32'(err_o), 32'd1);
        step("t5.start", 1, 0, 0, 0, 8);
        idle("t5.run", 2);
        step("t5.ignored", 1, 0, 0, 1, 3);
        chk("t5.cnt_cont", 32'(cnt_o), 32'd3);
        step("t5.ignored0", 1, 0, 0, 0, 0);
        idle("t5.run2", 10);

        // limit=1 periodic: done every cycle, period tally wraps
        step("t7.start", 1, 0, 0, 1, 1);
        idle("t7.run", 260);
        chk("t7.period_wrap", 32'(period_o), 32'd4);
        step("t7.stop", 0, 1, 0, 0, 0);

        // Async reset mid-run at cnt=37
        step("t6.start", 1, 0, 0, 0, 100);
        idle("t6.run", 37);
        chk("t6.at37", 32'(cnt_o), 32'd37);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outs("t6.reset");
        @(negedge clk);
        rst_n = 1'b1;
        step("t6.restart", 1, 0, 0, 0, 4);
        idle("t6.run2", 6);

        // Random commands
        for (int i = 0; i < 3000; i++) begin
            bit st, sp, pa, pe;
            int lim;
            st  = ($urandom_range(0, 9) == 0);
            sp  = ($urandom_range(0, 39) == 0);
            pa  = ($urandom_range(0, 5) == 0);
            pe  = $urandom_range(0, 1) == 1;
            case ($urandom_range(0, 9))
                0:       lim = 0;
                1:       lim = 127;
                default: lim = $urandom_range(1, 12);
            endcase
            step("rand", st, sp, pa, pe, lim);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
